// File: rtl/game_pkg.sv
// Shared types and constants for the cellular-automaton game controller.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LFSR  = 3'd1,
    LOAD  = 3'd2,
    PLAY  = 3'd3,
    PAUSE = 3'd4
  } statetype;

  localparam logic [63:0] DEFAULT_SEED_64 = 64'h0412_6424_0034_3C28;
  localparam logic [63:0] TAPS_64         = 64'hD800_0000_0000_0000;

endpackage

// File: rtl/game_ctrl_lfsr_galois.sv
// lfsr_galois: right-shifting Galois LFSR with enable, re-init and an all-zero lock guard.
module lfsr_galois #(
  parameter int               WIDTH = 64,
  parameter logic [WIDTH-1:0] TAPS  = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] INIT  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             load_init,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] shifted;

  always_comb begin
    shifted = (value >> 1) ^ (value[0] ? TAPS : '0);
  end

  // Zero is a fixed point of the register, so it is replaced by INIT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value <= INIT;
    end else if (load_init) begin
      value <= INIT;
    end else if (enable) begin
      value <= (shifted == '0) ? INIT : shifted;
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: seed/LFSR scramble, grid load and generation pacing for the game grid.
// Build macro GAME_CTRL_AUTOSTOP_EN: return to IDLE on the step reaching MAX_GEN.
module game_ctrl
  import game_pkg::*;
#(
  parameter int               WIDTH        = 64,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(DEFAULT_SEED_64),
  parameter logic [WIDTH-1:0] TAPS         = WIDTH'(TAPS_64),
  parameter int               GEN_DIV      = 25_000_000,
  parameter int               CNT_W        = 16,
  parameter int               MAX_GEN      = 1000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             randomize,
  output logic [WIDTH-1:0] seed,
  output logic             load,
  output logic             step,
  output logic [CNT_W-1:0] gen_count,
  output logic [2:0]       state
);

  localparam int               DIV_W    = $clog2(GEN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(GEN_DIV - 1);
`ifdef GAME_CTRL_AUTOSTOP_EN
  localparam bit AUTOSTOP = 1'b1;
`else
  localparam bit AUTOSTOP = 1'b0;
`endif

  statetype         state_q, state_d;
  logic             start_q;
  logic [WIDTH-1:0] seed_q, seed_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] gen_q, gen_d;
  logic [WIDTH-1:0] lfsr_value;
  logic             lfsr_en;
  logic             start_rise;
  logic             div_last;

  assign start_rise = start & ~start_q;
  assign div_last   = (div_q == DIV_LAST);

  lfsr_galois #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .INIT  (DEFAULT_SEED)
  ) u_lfsr (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (lfsr_en),
    .load_init (1'b0),
    .value     (lfsr_value)
  );

  always_comb begin
    state_d = state_q;
    seed_d  = seed_q;
    div_d   = div_q;
    gen_d   = gen_q;
    lfsr_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        lfsr_en = randomize;
        if (randomize) state_d = LFSR;
        else if (start_rise) state_d = LOAD;
      end
      LFSR: begin
        lfsr_en = randomize;
        if (!randomize) begin
          state_d = IDLE;
          seed_d  = lfsr_value;
        end
      end
      LOAD: begin
        div_d   = '0;
        gen_d   = '0;
        state_d = PLAY;
      end
      PLAY: begin
        // The step cycle always commits, even when leaving PLAY in the same cycle.
        if (div_last) begin
          div_d = '0;
          gen_d = gen_q + 1'b1;
        end else begin
          div_d = div_q + 1'b1;
        end
        if (randomize) state_d = IDLE;
        else if (start_rise) state_d = PAUSE;
        if (AUTOSTOP && div_last && (gen_d == CNT_W'(MAX_GEN))) state_d = IDLE;
      end
      PAUSE: begin
        if (randomize) state_d = IDLE;
        else if (start_rise) state_d = PLAY;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      seed_q  <= DEFAULT_SEED;
      div_q   <= '0;
      gen_q   <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start;
      seed_q  <= seed_d;
      div_q   <= div_d;
      gen_q   <= gen_q == gen_d ? gen_q : gen_d;
    end
  end

  // load/step are single-cycle pulses decoded from registered state only;
  // the grid samples them on the next rising clock edge, no acknowledge exists.
  assign load      = (state_q == LOAD);
  assign step      = (state_q == PLAY) && div_last;
  assign seed      = seed_q;
  assign gen_count = gen_q;
  assign state     = state_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: cycle reference model feeding an expected queue, plus directed probes.
module tb_game_ctrl;
  import game_pkg::*;

  localparam int          WIDTH   = 64;
  localparam int          GEN_DIV = 4;
  localparam int          CNT_W   = 2;
  localparam int          MAX_GEN = 3;
  localparam int          W       = 3 + WIDTH + CNT_W + 2;
  localparam logic [63:0] DEF     = 64'h0412_6424_0034_3C28;
  localparam logic [63:0] TAP     = 64'hD800_0000_0000_0000;
`ifdef GAME_CTRL_AUTOSTOP_EN
  localparam bit AUTOSTOP = 1'b1;
`else
  localparam bit AUTOSTOP = 1'b0;
`endif
  localparam int S_IDLE = 0, S_LFSR = 1, S_LOAD = 2, S_PLAY = 3, S_PAUSE = 4;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic             randomize = 1'b0;
  logic [WIDTH-1:0] seed;
  logic             load, step;
  logic [CNT_W-1:0] gen_count;
  logic [2:0]       state;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];

  game_ctrl #(
    .WIDTH   (WIDTH),
    .GEN_DIV (GEN_DIV),
    .CNT_W   (CNT_W),
    .MAX_GEN (MAX_GEN)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .randomize (randomize),
    .seed      (seed),
    .load      (load),
    .step      (step),
    .gen_count (gen_count),
    .state     (state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [63:0] lfsr_next(input logic [63:0] v);
    logic [63:0] n;
    n = v >> 1;
    if (v[0]) n = n ^ TAP;
    if (n == 64'd0) n = DEF;
    return n;
  endfunction

  int          m_state, m_next, m_div, m_gen;
  logic [63:0] m_seed, m_lfsr;
  bit          m_sq, m_rise;
  logic [W-1:0] m_word;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_state = S_IDLE; m_div = 0; m_gen = 0; m_seed = DEF; m_lfsr = DEF; m_sq = 1'b0;
    end else begin
      m_rise = start && !m_sq;
      m_sq   = start;
      m_next = m_state;
      case (m_state)
        S_IDLE: begin
          if (randomize) begin m_lfsr = lfsr_next(m_lfsr); m_next = S_LFSR; end
          else if (m_rise) m_next = S_LOAD;
        end
        S_LFSR: begin
          if (randomize) m_lfsr = lfsr_next(m_lfsr);
          else begin m_seed = m_lfsr; m_next = S_IDLE; end
        end
        S_LOAD: begin m_gen = 0; m_div = 0; m_next = S_PLAY; end
        S_PLAY: begin
          if (randomize) m_next = S_IDLE;
          else if (m_rise) m_next = S_PAUSE;
          if (m_div == GEN_DIV - 1) begin
            m_div = 0;
            m_gen = (m_gen + 1) % (1 << CNT_W);
            if (AUTOSTOP && m_gen == MAX_GEN) m_next = S_IDLE;
          end else begin
            m_div = m_div + 1;
          end
        end
        S_PAUSE: begin
          if (randomize) m_next = S_IDLE;
          else if (m_rise) m_next = S_PLAY;
        end
        default: m_next = S_IDLE;
      endcase
      m_state = m_next;
    end
    m_word = {m_state[2:0], m_seed, m_gen[CNT_W-1:0], 1'(m_state == S_LOAD),
              1'(m_state == S_PLAY && m_div == GEN_DIV - 1)};
    exp_q.push_back(m_word);
  end

  // ---------------- monitor / scoreboard ----------------
  logic [W-1:0] mon_exp, mon_act;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_act = {state, seed, gen_count, load, step};
      checks++;
      if (mon_act !== mon_exp) begin
        errors++;
        $display("FAIL outputs t=%0t actual {state,seed,gen,load,step}=%h required=%h",
                 $time, mon_act, mon_exp);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick(input logic s, input logic r);
    start = s;
    randomize = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    start = 1'b0;
    randomize = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [63:0] v;
    int steps_seen;
    int hold;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    check("reset_state", state, S_IDLE);
    check("reset_seed", seed, DEF);
    check("reset_pulses", {load, step}, 2'b00);
    check("reset_gen", gen_count, 0);

    // one-cycle randomize: single shift, lsb was 0 so no taps
    tick(0, 1);
    tick(0, 0);
    v = DEF;
    v = v >> 1;
    check("rand_1cycle_seed", seed, v);
    check("rand_1cycle_state", state, S_IDLE);

    do_reset();
    tick(0, 1);
    tick(0, 1);
    tick(0, 0);
    check("rand_2cycle_seed", seed, lfsr_next(lfsr_next(DEF)));

    // play with start held: load, then steps every GEN_DIV cycles
    do_reset();
    tick(1, 0);
    check("load_pulse", {state, load}, {3'(S_LOAD), 1'b1});
    steps_seen = 0;
    for (int c = 1; c <= 12; c++) begin
      tick(1, 0);
      check($sformatf("step_c%0d", c), step, 1'(c % GEN_DIV == 0));
    end
    tick(1, 0);
`ifdef GAME_CTRL_AUTOSTOP_EN
    check("autostop_state", state, S_IDLE);
    check("autostop_gen", gen_count, 3);
    repeat (6) tick(1, 0);
    check("autostop_hold", {state, gen_count}, {3'(S_IDLE), 2'd3});
`else
    check("gen_after_3", gen_count, 3);
    check("held_start_no_pause", state, S_PLAY);
    repeat (4) tick(1, 0);
    check("gen_wrap", gen_count, 0);
`endif

    // pause at frozen divider 2, resume
    do_reset();
    tick(1, 0);
    tick(0, 0);
    tick(0, 0);
    tick(1, 0);
    check("pause_enter", state, S_PAUSE);
    steps_seen = 0;
    for (int c = 0; c < 20; c++) begin
      tick(1, 0);
      if (step) steps_seen++;
    end
    check("pause_no_step", {state, 5'(steps_seen)}, {3'(S_PAUSE), 5'd0});
    tick(0, 0);
    tick(1, 0);
    check("resume_state", {state, step}, {3'(S_PLAY), 1'b0});
    tick(1, 0);
    check("resume_step", step, 1'b1);

    // start and randomize together in IDLE
    do_reset();
    tick(1, 1);
    check("simul_lfsr", {state, load}, {3'(S_LFSR), 1'b0});
    tick(1, 0);
    tick(1, 0);
    check("simul_no_load", {state, load}, {3'(S_IDLE), 1'b0});

    // asynchronous reset mid-PLAY
    do_reset();
    tick(1, 0);
    repeat (GEN_DIV + 3) tick(1, 0);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_reset", {state, seed, gen_count, load, step},
          {3'(S_IDLE), DEF, 2'd0, 1'b0, 1'b0});
    @(posedge clk);
    @(posedge clk);
    #1;
    start = 1'b0;
    randomize = 1'b0;
    reset_n = 1'b1;

    // random randomize hold lengths against the reference LFSR
    tick(0, 0);
    for (int i = 0; i < 1000; i++) begin
      hold = $urandom_range(1, 20);
      repeat (hold) tick(0, 1);
      tick(0, 0);
    end

    // free-running random input traffic
    for (int i = 0; i < 4000; i++) begin
      tick(($urandom_range(0, 5) == 0) ? ~start : start,
           ($urandom_range(0, 40) == 0) ? ~randomize : randomize);
    end

    tick(0, 0);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Top-level controller for the cellular-automaton game: holds the board seed, optionally scrambles it with a Galois LFSR, loads it into the grid, then paces generations with a programmable tick divider. It generalises the fixed 64-bit single-mode controller to a parametrised board width, programmable LFSR taps, pause/resume and a generation counter. It sits between the push-button synchronisers and the grid datapath.

## Interface
- WIDTH, 64: board bits (seed width); legal range 8..128.
- DEFAULT_SEED, 64'h0412_6424_0034_3C28 (zero-extended/truncated to WIDTH): reset seed.
- TAPS, 64'hD800_0000_0000_0000: Galois feedback mask (x^64+x^63+x^61+x^60+1), WIDTH bits.
- GEN_DIV, 25_000_000: clocks per generation; must be ≥2.
- CNT_W, 16: generation counter width.
- MAX_GEN, 1000: autostop limit, used only with GAME_CTRL_AUTOSTOP_EN.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  level; synchronised externally; rising edge is the command.
- randomize  in  1  level; LFSR runs while high.
- seed  out  WIDTH  current seed register.
- load  out  1  one-cycle pulse: grid captures seed.
- step  out  1  one-cycle pulse: grid computes next generation.
- gen_count  out  CNT_W  generations since last load.
- state  out  3  encoded current state (for LEDs/debug).

## Operation
- States: IDLE, LFSR, LOAD, PLAY, PAUSE.
- start_rise = start & ~start_q (start_q registered). Only start_rise acts; held start does nothing further.
- IDLE: randomize=1 → LFSR. start_rise (randomize=0) → LOAD. randomize has priority when both occur in the same cycle.
- LFSR: lfsr shifts once per clock (Galois: out=lfsr[0]; lfsr = (lfsr>>1) ^ (out ? TAPS : 0)). randomize=0 → IDLE with seed <= lfsr in that cycle. start ignored.
- Zero-lock guard: if lfsr would become all-zero, it is loaded with DEFAULT_SEED instead.
- LOAD: single cycle; load=1; gen_count cleared; divider cleared; → PLAY.
- PLAY: divider counts 0..GEN_DIV-1; step=1 in the cycle divider==GEN_DIV-1, divider wraps to 0, gen_count increments (wraps modulo 2^CNT_W). start_rise → PAUSE. randomize → IDLE (seed unchanged).
- PAUSE: divider and gen_count frozen, step=0. start_rise → PLAY (divider resumes from frozen value). randomize → IDLE.
- seed changes only on LFSR→IDLE exit; never while PLAY/PAUSE.

## Timing
- Reset (reset_n=0, asynchronous): state=IDLE, seed=DEFAULT_SEED, lfsr=DEFAULT_SEED, start_q=0, load=0, step=0, gen_count=0, divider=0.
- All outputs registered/Moore; load high exactly during the LOAD-state cycle, i.e. the cycle after the clock edge sampling start_rise.
- First step occurs GEN_DIV cycles after the LOAD cycle.
- start edge arriving in the same cycle as a step: step still issues, then PAUSE.
- Reset asserted mid-PLAY: immediate return to reset values; no trailing step/load pulse.
- Release of reset_n is synchronised externally; no requirement on the first cycle after release beyond reset values.

## Configuration
- GAME_CTRL_AUTOSTOP_EN defined: in PLAY, the step that brings gen_count to MAX_GEN also transitions to IDLE (gen_count holds MAX_GEN until next LOAD).
- Not defined: no generation limit; gen_count wraps; MAX_GEN unused.

## Structure
- game_pkg: statetype enum (IDLE=0, LFSR=1, LOAD=2, PLAY=3, PAUSE=4, logic [2:0]), DEFAULT_SEED_64 and TAPS_64 constants.
- Sub-module lfsr_galois #(WIDTH, TAPS, INIT): enable, load-init, zero-lock guard, value out.
- game_ctrl holds edge detect, FSM, divider, gen counter, seed register.

## Test plan
- Reset: reset_n=0 then 1 → seed=64'h0412_6424_0034_3C28, state=IDLE, load=step=0, gen_count=0.
- Randomize: randomize high exactly 1 cycle from reset → seed=DEFAULT_SEED>>1 (lsb 0, no tap); 2 cycles → second shift with taps applied per model; compare against reference LFSR model over 1000 random hold lengths.
- Start/play with GEN_DIV=4: start rise → load pulse next cycle; step pulses at cycles 4, 8, 12 after load; gen_count=3 after third.
- Pause: start rise in PLAY at divider=2 → no step for 20 cycles; start rise → next step 2 cycles after resume; held start produces no second toggle.
- Simultaneous events: start and randomize rise together in IDLE → LFSR, no load; reset_n low mid-PLAY → outputs at reset values immediately.
- Autostop (macro defined, MAX_GEN=3, GEN_DIV=4) → state returns to IDLE with third step, gen_count=3; macro undefined, CNT_W=2 → gen_count wraps 3→0.
